// File: rtl/systolic_pkg.sv
// Shared types and default dimensions for the systolic scheduler and array.
package systolic_pkg;

  localparam int MATRIX_SIZE_DEF = 2;
  localparam int DATA_SIZE_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying a data word plus its valid bit.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] dat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/systolic_scheduler.sv
// Weight-load / skewed-stream sequencer in front of systolic_array.
// SYSTOLIC_SCHED_ZERO_GATE_EN: zero out_data[i] whenever enable_mult[i] is low.
module systolic_scheduler
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int DATA_SIZE   = DATA_SIZE_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] w_data,
  input  logic                                  x_valid,
  output logic                                  x_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] x_data,
  input  logic                                  x_last,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_weights,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_data,
  output logic [MATRIX_SIZE-1:0]                load_weight,
  output logic [MATRIX_SIZE-1:0]                enable_mult,
  output logic                                  busy,
  output logic                                  done
);

  localparam int CNT_W = $clog2(MATRIX_SIZE + 1);

  sched_state_t                          state_q;
  logic [CNT_W-1:0]                      wcnt_q, wcnt_d;
  logic [CNT_W-1:0]                      dcnt_q;
  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_weights_q;
  logic [MATRIX_SIZE-1:0]                load_weight_q;
  logic                                  done_q;
  logic                                  w_fire, x_fire;

  assign busy    = (state_q != IDLE);
  assign w_ready = (state_q == IDLE) || (state_q == LOAD_W);
  assign x_ready = (state_q == STREAM);
  assign w_fire  = w_valid && w_ready;
  assign x_fire  = x_valid && x_ready;
  assign wcnt_d  = wcnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      dcnt_q        <= '0;
      out_weights_q <= '0;
      load_weight_q <= '0;
      done_q        <= 1'b0;
    end else begin
      load_weight_q <= '0;
      done_q        <= 1'b0;
      if (w_fire) begin
        out_weights_q <= w_data;
        load_weight_q <= '1;
      end
      case (state_q)
        IDLE: begin
          if (w_fire) begin
            wcnt_q  <= CNT_W'(1);
            state_q <= (MATRIX_SIZE == 1) ? STREAM : LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            wcnt_q <= wcnt_d;
            if (wcnt_d == CNT_W'(MATRIX_SIZE)) state_q <= STREAM;
          end
        end
        STREAM: begin
          if (x_fire && x_last) begin
            dcnt_q  <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // DRAIN spans exactly MATRIX_SIZE cycles, long enough for the deepest row
          if (dcnt_q == CNT_W'(MATRIX_SIZE - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_weights = out_weights_q;
  assign load_weight = load_weight_q;
  assign done        = done_q;

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_row
    logic [DATA_SIZE-1:0] line_in, line_out;

    // Outside STREAM only zero-data bubbles enter, so idle lines settle to zero
    assign line_in = (state_q == STREAM) ? x_data[i] : '0;

    skew_delay_line #(
      .DEPTH(i + 1),
      .WIDTH(DATA_SIZE)
    ) u_skew (
      .clk    (clk),
      .reset  (reset),
      .valid_i(x_fire),
      .data_i (line_in),
      .valid_o(enable_mult[i]),
      .data_o (line_out)
    );

`ifdef SYSTOLIC_SCHED_ZERO_GATE_EN
    assign out_data[i] = enable_mult[i] ? line_out : '0;
`else
    assign out_data[i] = line_out;
`endif
  end

endmodule

// File: tb/tb_systolic_scheduler.sv
// Scoreboard bench for systolic_scheduler with MATRIX_SIZE=2, DATA_SIZE=32.
module tb_systolic_scheduler;

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             w_valid, w_ready, x_valid, x_ready, x_last;
  logic [1:0][31:0] w_data, x_data, out_weights, out_data;
  logic [1:0]       load_weight, enable_mult;
  logic             busy, done;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  exp_t rq0[$], rq1[$], wq[$];
  int   dq[$];
  exp_t e;

`ifdef SYSTOLIC_SCHED_ZERO_GATE_EN
  localparam logic [31:0] BUB = 32'd0;
`else
  localparam logic [31:0] BUB = 32'd9;
`endif

  systolic_scheduler #(.MATRIX_SIZE(2), .DATA_SIZE(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_data     (x_data),
    .x_last     (x_last),
    .out_weights(out_weights),
    .out_data   (out_data),
    .load_weight(load_weight),
    .enable_mult(enable_mult),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack2(input logic [31:0] a, input logic [31:0] b);
    return {b, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      w_valid = 1'b1;
      w_data[0] = a;
      w_data[1] = b;
      if (w_ready) begin
        wq.push_back('{cyc + 1, pack2(a, b)});
        ok = 1'b1;
      end
    end
    if (!ok) check_val("w_timeout", {63'd0, w_ready}, 64'd1);
  endtask

  task automatic send_x(input logic [31:0] a, input logic [31:0] b, input logic last);
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      x_valid = 1'b1;
      x_data[0] = a;
      x_data[1] = b;
      x_last = last;
      if (x_ready) begin
        rq0.push_back('{cyc + 1, {32'd0, a}});
        rq1.push_back('{cyc + 2, {32'd0, b}});
        if (last) dq.push_back(cyc + 3);
        ok = 1'b1;
      end
    end
    if (!ok) check_val("x_timeout", {63'd0, x_ready}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (enable_mult[0]) begin
        if (rq0.size() == 0) check_val("row0_unexp", {63'd0, enable_mult[0]}, 64'd0);
        else begin
          e = rq0.pop_front();
          check_val("row0_cyc", cyc, e.cyc);
          check_val("row0_dat", {32'd0, out_data[0]}, e.val);
        end
      end
      if (enable_mult[1]) begin
        if (rq1.size() == 0) check_val("row1_unexp", {63'd0, enable_mult[1]}, 64'd0);
        else begin
          e = rq1.pop_front();
          check_val("row1_cyc", cyc, e.cyc);
          check_val("row1_dat", {32'd0, out_data[1]}, e.val);
        end
      end
      if (load_weight != 2'b00) begin
        check_val("lw_mask", {62'd0, load_weight}, 64'd3);
        if (wq.size() == 0) check_val("lw_unexp", {62'd0, load_weight}, 64'd0);
        else begin
          e = wq.pop_front();
          check_val("lw_cyc", cyc, e.cyc);
          check_val("w_dat", out_weights, e.val);
        end
      end
      if (done) begin
        if (dq.size() == 0) check_val("done_unexp", {63'd0, done}, 64'd0);
        else check_val("done_cyc", cyc, dq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    w_valid = 1'b0; x_valid = 1'b0; x_last = 1'b0;
    w_data = '0; x_data = '0;
    step();
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_val("rst_w_ready", {63'd0, w_ready}, 64'd1);
    check_val("rst_x_ready", {63'd0, x_ready}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_lw", {62'd0, load_weight}, 64'd0);
    check_val("rst_en", {62'd0, enable_mult}, 64'd0);
    check_val("rst_odata", out_data, 64'd0);
    check_val("rst_oweights", out_weights, 64'd0);

    // job 1: plain weight load and two-beat stream
    send_w(32'd1, 32'd2);
    send_w(32'd3, 32'd4);
    step();
    w_valid = 1'b0;
    check_val("ld_x_ready", {63'd0, x_ready}, 64'd1);
    check_val("ld_w_ready", {63'd0, w_ready}, 64'd0);
    check_val("ld_busy", {63'd0, busy}, 64'd1);
    send_x(32'd5, 32'd6, 1'b0);
    send_x(32'd7, 32'd8, 1'b1);
    step();
    x_valid = 1'b0; x_last = 1'b0;
    check_val("drain_x_ready", {63'd0, x_ready}, 64'd0);
    check_val("drain_w_ready", {63'd0, w_ready}, 64'd0);
    step();
    step();
    check_val("done_now", {63'd0, done}, 64'd1);
    check_val("done_w_ready", {63'd0, w_ready}, 64'd1);
    check_val("done_busy", {63'd0, busy}, 64'd0);

    // job 2: illegal weight during STREAM, then a bubble
    send_w(32'd11, 32'd12);
    send_w(32'd13, 32'd14);
    step();
    w_valid = 1'b1;
    w_data[0] = 32'd99; w_data[1] = 32'd99;
    check_val("ill_w_ready", {63'd0, w_ready}, 64'd0);
    step();
    w_valid = 1'b0;
    check_val("ill_lw", {62'd0, load_weight}, 64'd0);
    check_val("ill_oweights", out_weights, pack2(32'd13, 32'd14));
    send_x(32'd21, 32'd22, 1'b0);
    step();
    x_valid = 1'b0;
    x_data[0] = 32'd9; x_data[1] = 32'd9;
    send_x(32'd23, 32'd24, 1'b1);
    @(negedge clk);
    check_val("bub0_en", {63'd0, enable_mult[0]}, 64'd0);
    check_val("bub0_dat", {32'd0, out_data[0]}, {32'd0, BUB});
    step();
    x_valid = 1'b0; x_last = 1'b0;
    @(negedge clk);
    check_val("bub1_en", {63'd0, enable_mult[1]}, 64'd0);
    check_val("bub1_dat", {32'd0, out_data[1]}, {32'd0, BUB});
    for (int k = 0; k < 4; k++) step();

    // job 3: reset in the middle of STREAM
    send_w(32'd31, 32'd32);
    send_w(32'd33, 32'd34);
    step();
    w_valid = 1'b0;
    send_x(32'd41, 32'd42, 1'b0);
    step();
    x_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rq0.delete(); rq1.delete(); wq.delete(); dq.delete();
    @(negedge clk);
    check_val("mrst_en", {62'd0, enable_mult}, 64'd0);
    check_val("mrst_odata", out_data, 64'd0);
    check_val("mrst_busy", {63'd0, busy}, 64'd0);
    check_val("mrst_w_ready", {63'd0, w_ready}, 64'd1);
    check_val("mrst_done", {63'd0, done}, 64'd0);
    for (int k = 0; k < 5; k++) step();

    // job 4: single-beat job after the abort
    send_w(32'd51, 32'd52);
    send_w(32'd53, 32'd54);
    step();
    w_valid = 1'b0;
    send_x(32'd61, 32'd62, 1'b1);
    step();
    x_valid = 1'b0; x_last = 1'b0;
    for (int k = 0; k < 5; k++) step();

    check_val("queues_left", rq0.size() + rq1.size() + wq.size() + dq.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_scheduler.md
# systolic_scheduler

Front-end sequencer placed directly upstream of `systolic_array`. It accepts weight rows and input-data vectors over valid/ready handshakes, then drives the array's `in_weights`, `in_data`, `load_weight` and `enable_mult` ports. It runs a weight-load phase, then streams data with the diagonal skew that row `i` needs, a delay of `i` cycles. It also reports job completion once the skew pipeline has drained.

## Interface
Parameters:
- `MATRIX_SIZE`, default 2: array dimension (rows = columns).
- `DATA_SIZE`, default 32: width of each data and weight element.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `w_valid`  in  1  weight beat valid.
- `w_ready`  out  1  scheduler accepts a weight beat.
- `w_data`  in  `[DATA_SIZE-1:0] x MATRIX_SIZE`  one weight row per beat; element `j` goes to column `j`.
- `x_valid`  in  1  data beat valid.
- `x_ready`  out  1  scheduler accepts a data beat.
- `x_data`  in  `[DATA_SIZE-1:0] x MATRIX_SIZE`  one input vector per beat; element `i` goes to row `i`.
- `x_last`  in  1  marks the final data beat of the job; only sampled when a beat is accepted.
- `out_weights`  out  `[DATA_SIZE-1:0] x MATRIX_SIZE`  connects to array `in_weights`.
- `out_data`  out  `[DATA_SIZE-1:0] x MATRIX_SIZE`  connects to array `in_data`.
- `load_weight`  out  `MATRIX_SIZE`  connects to array `load_weight`.
- `enable_mult`  out  `MATRIX_SIZE`  connects to array `enable_mult`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job completion.

## Operation
- A beat transfers on any cycle where valid and ready are both high. The two handshakes are independent.
- The state machine has four states: IDLE (reset state), LOAD_W, STREAM, DRAIN.
- IDLE:
  - `w_ready` = 1, `x_ready` = 0.
  - An accepted weight beat sets the weight counter to 1 and moves to LOAD_W.
  - If `MATRIX_SIZE` = 1, it moves directly to STREAM instead.
- LOAD_W:
  - `w_ready` = 1.
  - Each accepted beat increments the weight counter.
  - When the counter reaches `MATRIX_SIZE` on an accepted beat, the next state is STREAM.
  - Weight beats are supplied bottom row first; the array shifts them down the columns.
- Every accepted weight beat, in IDLE or LOAD_W, registers `out_weights` = `w_data` and `load_weight` = all ones for exactly one cycle.
- With no weight beat accepted, `load_weight` = 0 and `out_weights` holds its last value.
- STREAM:
  - `x_ready` = 1, `w_ready` = 0; `w_valid` is ignored.
  - Each cycle, element `i` of `x_data`, tagged with a valid bit equal to the handshake, enters the row-`i` skew line.
  - A cycle with no accepted beat enters a bubble (valid bit 0).
  - An accepted beat with `x_last` = 1 moves the state to DRAIN.
- Skew line for row `i`: total delay of `i + 1` registers from acceptance to `out_data[i]`. `enable_mult[i]` is the delayed valid bit.
- DRAIN:
  - Both readies are 0; bubbles are shifted in.
  - The state lasts exactly `MATRIX_SIZE` cycles, counted by the drain counter.
  - It then returns to IDLE, with `done` registered high for one cycle.
- Counter widths: `$clog2(MATRIX_SIZE+1)` bits. There is no wrap; each counter is cleared on state entry.
- A job with zero data beats is not possible; STREAM waits indefinitely for `x_last`.

## Timing
- Data beat accepted at cycle t: `out_data[i]` and `enable_mult[i]` are valid at cycle t+1+i.
- Weight beat accepted at cycle t: `out_weights` and `load_weight` are valid at cycle t+1.
- Last data beat accepted at cycle L:
  - DRAIN covers cycles L+1 to L+MATRIX_SIZE.
  - `done` is high at L+MATRIX_SIZE+1, with the state back in IDLE.
  - `w_ready` is 1 from that cycle.
- `busy` is combinational from state. Ready signals are combinational from state only, with no dependency on valid.
- Reset state, effective in the cycle after `reset` is sampled high:
  - All outputs are 0 except `w_ready` = 1.
  - All skew lines and counters are cleared.
- Reset mid-job aborts with no `done` pulse.

## Configuration
- `SYSTOLIC_SCHED_ZERO_GATE_EN`:
  - Defined: `out_data[i]` is forced to 0 whenever `enable_mult[i]` = 0 (bubbles, DRAIN tail, IDLE).
  - Undefined: `out_data[i]` shows the raw skew-line contents. Bubble slots carry the `x_data` sampled on that cycle; the array ignores them because enable is low.
- Handshake and timing are identical in both builds.

## Structure
- Shared package `systolic_pkg`:
  - `sched_state_t` enum {IDLE, LOAD_W, STREAM, DRAIN}.
  - Default `MATRIX_SIZE` and `DATA_SIZE` constants, also used by `systolic_array`.
- Sub-module `skew_delay_line`:
  - Parameters `DEPTH` and `WIDTH`; carries data plus valid bit, cleared by `reset`.
  - One instance per row, with `DEPTH` = i+1.

## Test plan
All scenarios use `MATRIX_SIZE` = 2 and `DATA_SIZE` = 32.
- Weight load: reset, then weight beats {1,2} at t0 and {3,4} at t0+1.
  - `load_weight` = 2'b11 at t0+1 and t0+2; `out_weights` = {1,2} then {3,4}.
  - `x_ready` = 1 from t0+2.
- Stream: data beats {5,6} at T and {7,8} with `x_last` at T+1.
  - `out_data[0]` = 5, 7 at T+1, T+2; `out_data[1]` = 6, 8 at T+2, T+3.
  - `enable_mult` = 01, 11, 10; `done` pulses at T+4.
- Bubble: beats at T and T+2 with `x_valid` low at T+1.
  - `enable_mult[0]` = 1,0,1 over T+1..T+3; `enable_mult[1]` = 1,0,1 over T+2..T+4.
- Illegal weight: `w_valid` = 1 during STREAM.
  - `w_ready` = 0, `load_weight` stays 0, and `out_weights` is unchanged.
- Reset mid-STREAM: assert `reset` for one cycle.
  - Next cycle: all `enable_mult` and `out_data` = 0, `busy` = 0, `w_ready` = 1, and no `done` pulse.
- Zero gate (with `SYSTOLIC_SCHED_ZERO_GATE_EN`): same stimulus as the Bubble scenario, with `x_data` = {9,9} during the gap.
  - `out_data` = 0 in the bubble slots.
  - Without the macro, 9 appears on `out_data` in those slots with enable low.
